// File: rtl/pack8to256_if.sv
// Byte-in / word-out bus of the 8-to-256 packer.
// Latency: none, signal bundle only.
// Backpressure: full gates the byte side, empty/rden form the FWFT word side.
interface pack8to256_if #(
  parameter int OUT_WIDTH = 256
);
  logic [7:0]           data8;
  logic                 wren;
  logic                 full;
  logic                 flush;
  logic [OUT_WIDTH-1:0] data256;
  logic                 empty;
  logic                 rden;
  logic                 overflow;

  // Producer/consumer side: drives bytes, flush and pops.
  modport master (
    output data8, wren, flush, rden,
    input  full, data256, empty, overflow
  );

  // Packer side.
  modport slave (
    input  data8, wren, flush, rden,
    output full, data256, empty, overflow
  );
endinterface

// File: rtl/pack8to256.sv
// Packs UART bytes little-endian into OUT_WIDTH words behind a one-word FWFT holding register.
// Latency: last byte (or flush) accepted in cycle N -> word visible, empty=0, in cycle N+1.
// Backpressure: full = flush pending or (last lane next and hold occupied); offered bytes while full are dropped and set sticky overflow.
module pack8to256 #(
  parameter int         OUT_WIDTH = 256,
  parameter logic [7:0] FILL      = 8'h00
) (
  input  logic         clock,
  input  logic         rst_n,
  pack8to256_if.slave  bus
);
  localparam int BYTES = OUT_WIDTH / 8;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] hold;
  logic [CW-1:0]        cnt;
  logic                 hold_vld;
  logic                 flush_pend;
  logic                 overflow;

  logic                 full;
  logic                 accept;
  logic                 hold_free;
  logic                 complete;
  logic                 flush_go;
  logic                 load_flush;
  logic                 load;
  logic [CW:0]          count_next;
  logic [OUT_WIDTH-1:0] acc_next;
  logic [OUT_WIDTH-1:0] padded;

  // full depends on registers only, so no combinational path from rden.
  assign full       = flush_pend || (cnt == LAST && hold_vld);
  assign accept     = bus.wren && !full;
  assign hold_free  = !hold_vld || bus.rden;
  assign count_next = {1'b0, cnt} + (CW+1)'(accept);
  // Completion implies hold is empty: with hold busy the last lane is blocked by full.
  assign complete   = accept && (cnt == LAST);
  // A flush that rides on a natural completion is absorbed into that word.
  assign flush_go   = bus.flush && !flush_pend && !complete && (count_next != '0);
  assign load_flush = (flush_go || flush_pend) && hold_free;
  assign load       = complete || load_flush;

  // Accumulator with this cycle's byte merged in, and its padded image for flushing.
  always_comb begin
    acc_next = acc;
    if (accept) acc_next[{cnt, 3'b000} +: 8] = bus.data8;
    padded = '0;
    for (int i = 0; i < BYTES; i++) begin
      padded[i*8 +: 8] = (i < int'(count_next)) ? acc_next[i*8 +: 8] : FILL;
    end
  end

  // Byte collection, word hand-off into hold, flush deferral and sticky overflow.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      hold       <= '0;
      cnt        <= '0;
      hold_vld   <= 1'b0;
      flush_pend <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      acc <= acc_next;
      cnt <= load ? '0 : count_next[CW-1:0];
      // A complete word has no lanes at or above count, so padded == acc_next then.
      if (load) hold <= padded;
      if (load)          hold_vld <= 1'b1;
      else if (bus.rden) hold_vld <= 1'b0;
      if (load_flush)                 flush_pend <= 1'b0;
      else if (flush_go && !hold_free) flush_pend <= 1'b1;
      if (bus.wren && full) overflow <= 1'b1;
    end
  end

  assign bus.full     = full;
  assign bus.data256  = hold;
  assign bus.empty    = !hold_vld;
  assign bus.overflow = overflow;
endmodule

// File: tb/tb_pack8to256.sv
module tb_pack8to256;
  localparam int OUT_WIDTH = 256;
  localparam int BYTES     = OUT_WIDTH / 8;
  localparam logic [7:0] FILL = 8'h00;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  pack8to256_if #(.OUT_WIDTH(OUT_WIDTH)) bus ();

  pack8to256 #(.OUT_WIDTH(OUT_WIDTH), .FILL(FILL)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model: pending bytes as a queue, one held word, flush-deferred flag.
  logic [7:0]           part[$];
  logic [OUT_WIDTH-1:0] popped[$];
  logic [OUT_WIDTH-1:0] m_hold;
  bit                   m_hvld, m_pend, m_ovf;

  int tests_run = 0;
  int failures  = 0;

  function automatic logic [OUT_WIDTH-1:0] pack_part();
    logic [OUT_WIDTH-1:0] w;
    for (int i = 0; i < BYTES; i++) w[i*8 +: 8] = (i < part.size()) ? part[i] : FILL;
    return w;
  endfunction

  task automatic check(input string tag, input logic [OUT_WIDTH-1:0] obs, input logic [OUT_WIDTH-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("empty", OUT_WIDTH'(bus.empty), OUT_WIDTH'(!m_hvld));
    check("full", OUT_WIDTH'(bus.full), OUT_WIDTH'(m_pend || (part.size() == BYTES-1 && m_hvld)));
    check("overflow", OUT_WIDTH'(bus.overflow), OUT_WIDTH'(m_ovf));
    if (m_hvld) check("data256", bus.data256, m_hold);
  endtask

  // One clock of stimulus; the model advances from the same inputs.
  task automatic step(input bit w, input logic [7:0] d, input bit f, input bit r);
    bit mf, acc_ok, hf, loaded;
    @(negedge clock);
    bus.wren = w; bus.data8 = d; bus.flush = f; bus.rden = r;
    mf     = m_pend || (part.size() == BYTES-1 && m_hvld);
    acc_ok = w && !mf;
    if (w && mf) m_ovf = 1'b1;
    hf     = !m_hvld || r;
    if (r && m_hvld) popped.push_back(m_hold);
    loaded = 1'b0;
    if (acc_ok) part.push_back(d);
    if (part.size() == BYTES) begin
      m_hold = pack_part(); part.delete(); loaded = 1'b1;
    end else if (m_pend || (f && part.size() > 0)) begin
      if (hf) begin
        m_hold = pack_part(); part.delete(); m_pend = 1'b0; loaded = 1'b1;
      end else begin
        m_pend = 1'b1;
      end
    end
    if (loaded) m_hvld = 1'b1;
    else if (r) m_hvld = 1'b0;
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst_n = 1'b0;
    bus.wren = 1'b0; bus.data8 = '0; bus.flush = 1'b0; bus.rden = 1'b0;
    part.delete(); m_hvld = 1'b0; m_pend = 1'b0; m_ovf = 1'b0; m_hold = '0;
    #1;
    check("rst_empty", OUT_WIDTH'(bus.empty), OUT_WIDTH'(1));
    check("rst_full", OUT_WIDTH'(bus.full), OUT_WIDTH'(0));
    check("rst_overflow", OUT_WIDTH'(bus.overflow), OUT_WIDTH'(0));
    check("rst_data256", bus.data256, '0);
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [OUT_WIDTH-1:0] exp_w;
    logic [7:0]           b;
    int                   n0;

    bus.wren = 1'b0; bus.data8 = '0; bus.flush = 1'b0; bus.rden = 1'b0;
    #2;
    do_reset();

    // Test 1: 0x00..0x1F with rden=1 -> word visible one cycle after the last byte.
    for (int i = 0; i < BYTES; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
    for (int i = 0; i < BYTES; i++) exp_w[i*8 +: 8] = 8'(i);
    check("t1_empty", OUT_WIDTH'(bus.empty), OUT_WIDTH'(0));
    check("t1_word", bus.data256, exp_w);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Test 2: 96 bytes, rden low until byte 64 -> byte 64 dropped, two words out.
    do_reset();
    n0 = popped.size();
    for (int i = 1; i <= 96; i++) begin
      if (i == 64) check("t2_full_at_64", OUT_WIDTH'(bus.full), OUT_WIDTH'(1));
      step(1'b1, 8'($urandom), 1'b0, i >= 64);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    check("t2_overflow", OUT_WIDTH'(bus.overflow), OUT_WIDTH'(1));
    check("t2_words", OUT_WIDTH'(popped.size() - n0), OUT_WIDTH'(2));

    // Test 3: 5 bytes then flush -> padded with FILL.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t3_word", bus.data256, {216'b0, 40'hA5A4A3A2A1});
    step(1'b0, 8'h00, 1'b0, 1'b1);
    // Partial-count reset: a fresh full word must land cleanly in lanes 0..31.
    for (int i = 0; i < BYTES; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < BYTES; i++) exp_w[i*8 +: 8] = 8'h40 + 8'(i);
    check("t3_next_word", bus.data256, exp_w);

    // Test 4: hold busy, 3 bytes, flush with no pops -> full held, padded word after pop.
    do_reset();
    for (int i = 0; i < BYTES; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    exp_w = '0;
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      exp_w[i*8 +: 8] = b;
      step(1'b1, b, 1'b0, 1'b0);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, i == 1, 1'b0);
      check("t4_full_held", OUT_WIDTH'(bus.full), OUT_WIDTH'(1));
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("t4_empty", OUT_WIDTH'(bus.empty), OUT_WIDTH'(0));
    check("t4_padded", bus.data256, exp_w);
    n0 = popped.size();
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    check("t4_single_word", OUT_WIDTH'(popped.size() - n0), OUT_WIDTH'(1));

    // Flush together with byte 31 -> one unpadded word only.
    for (int i = 0; i < BYTES; i++) step(1'b1, 8'hC0 + 8'(i), i == BYTES-1, 1'b0);
    for (int i = 0; i < BYTES; i++) exp_w[i*8 +: 8] = 8'hC0 + 8'(i);
    check("flush_on_last", bus.data256, exp_w);
    n0 = popped.size();
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    check("flush_on_last_count", OUT_WIDTH'(popped.size() - n0), OUT_WIDTH'(1));

    // Test 5: 320 bytes at 1 byte/clk with rden = !empty -> 10 words, never full.
    do_reset();
    n0 = popped.size();
    for (int i = 0; i < 320; i++) step(1'b1, 8'($urandom), 1'b0, !bus.empty);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, !bus.empty);
    check("t5_words", OUT_WIDTH'(popped.size() - n0), OUT_WIDTH'(10));
    check("t5_overflow", OUT_WIDTH'(bus.overflow), OUT_WIDTH'(0));

    // Test 6: reset at byte 17, then 32 new bytes form the next word alone.
    for (int i = 0; i < 17; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < BYTES; i++) begin
      b = 8'($urandom);
      exp_w[i*8 +: 8] = b;
      step(1'b1, b, 1'b0, 1'b0);
    end
    check("t6_word", bus.data256, exp_w);

    // Random mix of bytes, flushes and pops against the model.
    do_reset();
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end
endmodule
